// File: rtl/prm_edge_mask_engine.sv
// Sequential product-term scanner: builds an N_EDGE collision mask for one configuration per query.
// Optional PRM_MASK_EARLY_EXIT_EN ends the scan once every mask bit is set; results are identical either way.
module prm_edge_mask_engine #(
  parameter int IN_W       = 15,
  parameter int N_EDGE     = 8,
  parameter int TERM_DEPTH = 256,
  parameter int EID_W      = (N_EDGE > 1) ? $clog2(N_EDGE) : 1,
  parameter int TERM_AW    = $clog2(TERM_DEPTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_cfg_we,
  input  logic [TERM_AW-1:0] i_cfg_addr,
  input  logic [IN_W-1:0]    i_cfg_care,
  input  logic [IN_W-1:0]    i_cfg_val,
  input  logic [EID_W-1:0]   i_cfg_eid,
  input  logic               i_cfg_cnt_we,
  input  logic [TERM_AW:0]   i_cfg_cnt,
  output logic               o_cfg_busy,
  input  logic               i_q_valid,
  output logic               o_q_ready,
  input  logic [IN_W-1:0]    i_q_cfg,
  output logic               o_m_valid,
  input  logic               i_m_ready,
  output logic [N_EDGE-1:0]  o_m_mask
);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

  localparam logic [TERM_AW:0] L_DEPTH = (TERM_AW+1)'(TERM_DEPTH);

  state_t r_state, w_state_nxt;

  logic [IN_W-1:0]  r_care [TERM_DEPTH];
  logic [IN_W-1:0]  r_val  [TERM_DEPTH];
  logic [EID_W-1:0] r_eid  [TERM_DEPTH];

  logic               r_live;
  logic [TERM_AW:0]   r_term_cnt;
  logic [TERM_AW:0]   r_scan_cnt;
  logic [TERM_AW-1:0] r_idx;
  logic [IN_W-1:0]    r_qcfg;
  logic [N_EDGE-1:0]  r_acc;

  logic               r_pend_vld;
  logic [TERM_AW-1:0] r_pend_addr;
  logic [IN_W-1:0]    r_pend_care;
  logic [IN_W-1:0]    r_pend_val;
  logic [EID_W-1:0]   r_pend_eid;

  logic               w_idle, w_accept, w_cfg_ok, w_commit, w_wr_en;
  logic [TERM_AW-1:0] w_wr_addr;
  logic [IN_W-1:0]    w_wr_care, w_wr_val;
  logic [EID_W-1:0]   w_wr_eid;
  logic               w_hit, w_last, w_full, w_scan_end;
  logic [N_EDGE-1:0]  w_acc_nxt;

  assign w_idle   = (r_state == S_IDLE);
  assign w_accept = i_q_valid & o_q_ready;
  assign w_cfg_ok = w_idle & i_cfg_we;
  assign w_commit = r_pend_vld & (r_state == S_DONE) & i_m_ready;

  // A slot write landing on the acceptance edge is parked until the query retires.
  assign w_wr_en   = (w_cfg_ok & ~w_accept) | w_commit;
  assign w_wr_addr = w_commit ? r_pend_addr : i_cfg_addr;
  assign w_wr_care = w_commit ? r_pend_care : i_cfg_care;
  assign w_wr_val  = w_commit ? r_pend_val  : i_cfg_val;
  assign w_wr_eid  = w_commit ? r_pend_eid  : i_cfg_eid;

  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_care[w_wr_addr] <= w_wr_care;
      r_val[w_wr_addr]  <= w_wr_val;
      r_eid[w_wr_addr]  <= w_wr_eid;
    end
  end

  assign w_hit = ~|((r_qcfg ^ r_val[r_idx]) & r_care[r_idx]);

  // Out-of-range edge ids match no bit position and so contribute nothing.
  always_comb begin
    w_acc_nxt = r_acc;
    for (int e = 0; e < N_EDGE; e++) begin
      if (w_hit && (int'(r_eid[r_idx]) == e)) w_acc_nxt[e] = 1'b1;
    end
  end

  assign w_last = (({1'b0, r_idx} + (TERM_AW+1)'(1)) == r_scan_cnt);
  assign w_full = &w_acc_nxt;

`ifdef PRM_MASK_EARLY_EXIT_EN
  assign w_scan_end = w_last | w_full;
`else
  assign w_scan_end = w_last;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_state_nxt = (r_term_cnt != '0) ? S_SCAN : S_DONE;
      S_SCAN: if (w_scan_end) w_state_nxt = S_DONE;
      S_DONE: if (i_m_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    o_q_ready  = r_live & w_idle;
    o_cfg_busy = ~w_idle;
    o_m_valid  = (r_state == S_DONE);
    o_m_mask   = (r_state == S_DONE) ? r_acc : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_live      <= 1'b0;
      r_term_cnt  <= '0;
      r_scan_cnt  <= '0;
      r_idx       <= '0;
      r_qcfg      <= '0;
      r_acc       <= '0;
      r_pend_vld  <= 1'b0;
      r_pend_addr <= '0;
      r_pend_care <= '0;
      r_pend_val  <= '0;
      r_pend_eid  <= '0;
    end else begin
      r_live <= 1'b1;
      if (i_cfg_cnt_we && w_idle)
        r_term_cnt <= (i_cfg_cnt > L_DEPTH) ? L_DEPTH : i_cfg_cnt;
      if (w_accept) begin
        r_qcfg     <= i_q_cfg;
        r_acc      <= '0;
        r_idx      <= '0;
        r_scan_cnt <= r_term_cnt;
      end else if (r_state == S_SCAN) begin
        r_acc <= w_acc_nxt;
        r_idx <= r_idx + TERM_AW'(1);
      end
      if (w_cfg_ok && w_accept) begin
        r_pend_vld  <= 1'b1;
        r_pend_addr <= i_cfg_addr;
        r_pend_care <= i_cfg_care;
        r_pend_val  <= i_cfg_val;
        r_pend_eid  <= i_cfg_eid;
      end else if (w_commit) begin
        r_pend_vld <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_prm_edge_mask_engine.sv
// Bench for prm_edge_mask_engine: table vectors through a scoreboard plus hand sequences.
module tb_prm_edge_mask_engine;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  int n_chk = 0;
  int n_pass = 0;

`ifdef PRM_MASK_EARLY_EXIT_EN
  localparam int EE_LAT_200 = 2;
  localparam int EE_LAT_SAT = 2;
`else
  localparam int EE_LAT_200 = 200;
  localparam int EE_LAT_SAT = 256;
`endif

  // main instance: N_EDGE 8 with a 4-bit edge id so out-of-range ids can be stored
  logic        cfg_we = 0, cfg_cnt_we = 0, cfg_busy;
  logic [7:0]  cfg_addr = 0;
  logic [14:0] cfg_care = 0, cfg_val = 0, q_cfg = 0;
  logic [3:0]  cfg_eid = 0;
  logic [8:0]  cfg_cnt = 0;
  logic        q_valid = 0, q_ready, m_valid, m_ready = 1;
  logic [7:0]  m_mask;

  prm_edge_mask_engine #(.N_EDGE(8), .EID_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_cfg_we(cfg_we), .i_cfg_addr(cfg_addr), .i_cfg_care(cfg_care),
    .i_cfg_val(cfg_val), .i_cfg_eid(cfg_eid),
    .i_cfg_cnt_we(cfg_cnt_we), .i_cfg_cnt(cfg_cnt), .o_cfg_busy(cfg_busy),
    .i_q_valid(q_valid), .o_q_ready(q_ready), .i_q_cfg(q_cfg),
    .o_m_valid(m_valid), .i_m_ready(m_ready), .o_m_mask(m_mask));

  // two-edge instance for the early-exit and count-saturation sequences
  logic        b_cfg_we = 0, b_cfg_cnt_we = 0, b_cfg_busy;
  logic [7:0]  b_cfg_addr = 0;
  logic [14:0] b_cfg_care = 0, b_cfg_val = 0, b_q_cfg = 0;
  logic        b_cfg_eid = 0;
  logic [8:0]  b_cfg_cnt = 0;
  logic        b_q_valid = 0, b_q_ready, b_m_valid, b_m_ready = 1;
  logic [1:0]  b_m_mask;

  prm_edge_mask_engine #(.N_EDGE(2)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .i_cfg_we(b_cfg_we), .i_cfg_addr(b_cfg_addr), .i_cfg_care(b_cfg_care),
    .i_cfg_val(b_cfg_val), .i_cfg_eid(b_cfg_eid),
    .i_cfg_cnt_we(b_cfg_cnt_we), .i_cfg_cnt(b_cfg_cnt), .o_cfg_busy(b_cfg_busy),
    .i_q_valid(b_q_valid), .o_q_ready(b_q_ready), .i_q_cfg(b_q_cfg),
    .o_m_valid(b_m_valid), .i_m_ready(b_m_ready), .o_m_mask(b_m_mask));

  typedef struct {
    logic [7:0] mask;
    int         lat;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [14:0] cfg;
    logic [7:0]  mask;
  } vec_t;
  vec_t vt[6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=0x%0h required=0x%0h", nm, act, exp);
  endtask

  // Monitor: latency runs from the acceptance edge to the first cycle m_valid is seen.
  int  acc_edge = 0;
  int  lat = 0;
  bit  seen = 0;
  always @(negedge clk) begin
    if (q_valid && q_ready) acc_edge = cyc + 1;
    if (m_valid && !seen) begin
      seen = 1;
      lat = cyc - acc_edge;
    end
    if (m_valid && m_ready) begin
      seen = 0;
      chk("sb_nonempty", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("mask", 32'(m_mask), 32'(e.mask));
        chk("latency", 32'(lat), 32'(e.lat));
      end
    end
  end

  task automatic wr(input logic [7:0] a, input logic [14:0] care, input logic [14:0] val,
                    input logic [3:0] eid);
    @(posedge clk); #1;
    cfg_addr = a; cfg_care = care; cfg_val = val; cfg_eid = eid; cfg_we = 1;
    @(posedge clk); #1;
    cfg_we = 0;
  endtask

  task automatic set_cnt(input logic [8:0] c);
    @(posedge clk); #1;
    cfg_cnt = c; cfg_cnt_we = 1;
    @(posedge clk); #1;
    cfg_cnt_we = 0;
  endtask

  task automatic send(input logic [14:0] c, input logic [7:0] em, input int el,
                      input bit push, input bit with_cfg, output int a_edge);
    bit got;
    exp_t e;
    got = 0;
    a_edge = 0;
    @(posedge clk); #1;
    q_valid = 1; q_cfg = c;
    if (with_cfg) cfg_we = 1;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      if (q_ready) begin got = 1; break; end
    end
    chk("accept", 32'(got), 32'd1);
    if (got) begin
      a_edge = cyc + 1;
      e.mask = em; e.lat = el;
      if (push) sb.push_back(e);
    end
    @(posedge clk); #1;
    q_valid = 0; cfg_we = 0;
  endtask

  task automatic drain();
    bit ok;
    ok = 0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (sb.size() == 0 && q_ready) begin ok = 1; break; end
    end
    chk("drain", 32'(ok), 32'd1);
  endtask

  task automatic wr2(input logic [7:0] a, input logic eid);
    @(posedge clk); #1;
    b_cfg_addr = a; b_cfg_care = 0; b_cfg_val = 0; b_cfg_eid = eid; b_cfg_we = 1;
    @(posedge clk); #1;
    b_cfg_we = 0;
  endtask

  task automatic run2(input logic [8:0] cnt, input int exp_lat);
    bit got;
    int a;
    @(posedge clk); #1;
    b_cfg_cnt = cnt; b_cfg_cnt_we = 1;
    @(posedge clk); #1;
    b_cfg_cnt_we = 0; b_q_cfg = 15'($urandom); b_q_valid = 1;
    got = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (b_q_ready) begin got = 1; break; end
    end
    chk("q2_accept", 32'(got), 32'd1);
    a = cyc + 1;
    @(posedge clk); #1;
    b_q_valid = 0;
    got = 0;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      if (b_m_valid) begin got = 1; break; end
    end
    chk("q2_valid", 32'(got), 32'd1);
    chk("q2_latency", 32'(cyc - a), 32'(exp_lat));
    chk("q2_mask", 32'(b_m_mask), 32'h3);
    @(posedge clk); #1;
  endtask

  initial begin
    int a_edge, prev;
    vt[0] = '{15'h4015, 8'h25};
    vt[1] = '{15'h0002, 8'h20};
    vt[2] = '{15'h0001, 8'h21};
    vt[3] = '{15'h7FFD, 8'h21};
    vt[4] = '{15'h4017, 8'h20};
    vt[5] = '{15'h0005, 8'h21};

    // reset values while rst_n is low
    repeat (2) @(negedge clk);
    chk("rst_q_ready", 32'(q_ready), 32'd0);
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_m_mask", 32'(m_mask), 32'd0);
    chk("rst_cfg_busy", 32'(cfg_busy), 32'd0);
    @(posedge clk); #1;
    rst_n = 1;
    repeat (2) @(negedge clk);
    chk("post_rst_q_ready", 32'(q_ready), 32'd1);

    // three-term table, back-to-back queries at one per term_cnt+2 cycles
    wr(8'd0, 15'h7FFF, 15'h4015, 4'd2);
    wr(8'd1, 15'h0003, 15'h0001, 4'd0);
    wr(8'd2, 15'h0000, 15'h0000, 4'd5);
    set_cnt(9'd3);
    prev = 0;
    for (int i = 0; i < 6; i++) begin
      send(vt[i].cfg, vt[i].mask, 3, 1, 0, a_edge);
      if (i > 0) chk("spacing", 32'(a_edge - prev), 32'd5);
      prev = a_edge;
    end
    drain();

    // empty table
    set_cnt(9'd0);
    send(15'h4015, 8'h00, 0, 1, 0, a_edge);
    drain();

    // eid 9 term; writes during the scan must not land
    wr(8'd3, 15'h0000, 15'h0000, 4'd9);
    set_cnt(9'd4);
    send(15'h0002, 8'h20, 4, 1, 0, a_edge);
    @(negedge clk);
    chk("busy_in_scan", 32'(cfg_busy), 32'd1);
    wr(8'd2, 15'h0000, 15'h0000, 4'd1);
    set_cnt(9'd0);
    drain();
    send(15'h0002, 8'h20, 4, 1, 0, a_edge);
    drain();

    // write on the acceptance edge applies to the following query only
    cfg_addr = 8'd2; cfg_care = 15'h0; cfg_val = 15'h0; cfg_eid = 4'd0;
    send(15'h0002, 8'h20, 4, 1, 1, a_edge);
    drain();
    send(15'h0002, 8'h01, 4, 1, 0, a_edge);
    drain();

    // backpressure
    m_ready = 0;
    send(15'h4015, 8'h05, 4, 1, 0, a_edge);
    begin
      bit got;
      got = 0;
      for (int k = 0; k < 50; k++) begin
        @(negedge clk);
        if (m_valid) begin got = 1; break; end
      end
      chk("bp_valid", 32'(got), 32'd1);
    end
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("bp_mask_hold", 32'(m_mask), 32'h05);
      chk("bp_valid_hold", 32'(m_valid), 32'd1);
      chk("bp_q_ready", 32'(q_ready), 32'd0);
    end
    @(posedge clk); #1;
    m_ready = 1;
    @(negedge clk);
    chk("bp_hs_q_ready", 32'(q_ready), 32'd0);
    @(negedge clk);
    chk("bp_release_q_ready", 32'(q_ready), 32'd1);
    drain();

    // reset in the middle of a scan
    send(15'h0000, 8'h00, 0, 0, 0, a_edge);
    @(negedge clk);
    chk("abort_busy", 32'(cfg_busy), 32'd1);
    @(posedge clk); #1;
    rst_n = 0;
    #1;
    chk("abort_m_valid", 32'(m_valid), 32'd0);
    chk("abort_q_ready", 32'(q_ready), 32'd0);
    chk("abort_cfg_busy", 32'(cfg_busy), 32'd0);
    @(posedge clk); #1;
    rst_n = 1;
    send(15'h4015, 8'h00, 0, 1, 0, a_edge);
    drain();

    // early exit and count saturation on the two-edge instance
    wr2(8'd0, 1'b0);
    wr2(8'd1, 1'b1);
    run2(9'd200, EE_LAT_200);
    run2(9'h1FF, EE_LAT_SAT);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
